// File: rtl/dds_sd_dac_if.sv
// Sample/enable bus into the delta-sigma DAC and its pulse-density outputs.
// Handshake: sample is captured on every rising edge where sample_vld=1; no ready, no backpressure.
interface dds_sd_dac_if #(parameter int W = 12);
    logic         en;
    logic [W-1:0] sample;
    logic         sample_vld;
    logic         sd_out;
    logic         active;

    modport master (output en, sample, sample_vld, input sd_out, active);
    modport slave  (input en, sample, sample_vld, output sd_out, active);
endinterface

// File: rtl/dds_sd_dac.sv
// First-order delta-sigma modulator turning a held DDS sample into a 1-bit density stream.
// Optional LFSR dither on the LSB is compiled in with `define DDS_SD_DITHER_EN.
module dds_sd_dac #(
    parameter int W         = 12,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    dds_sd_dac_if.slave   bus_if,
    output logic          dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [W-1:0] PRIME = {1'b1, {(W-1){1'b0}}};

    state_t       state_q;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] h_q;
    logic         sd_q, carry_d;
    logic         active_q;
    logic [W-1:0] u;
    logic [W-1:0] x;
    logic [W:0]   sum;
    logic         modulate;

    // Two's complement to offset binary is just an MSB flip.
    always_comb begin
        u = bus_if.sample;
        if (SIGNED_IN) u = {~bus_if.sample[W-1], bus_if.sample[W-2:0]};
    end

    assign modulate = (state_q == RUN) && bus_if.en;

`ifdef DDS_SD_DITHER_EN
    logic [15:0] lfsr_q;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        lfsr_q <= 16'hACE1;
        else if (modulate) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        x = h_q;
        if (!(&h_q)) x = h_q + {{(W-1){1'b0}}, lfsr_q[0]};
    end
`else
    always_comb x = h_q;
`endif

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, x};
        acc_d   = sum[W-1:0];
        carry_d = sum[W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= PRIME;
            h_q      <= PRIME;
            sd_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            if (bus_if.sample_vld) h_q <= u;
            case (state_q)
                IDLE: begin
                    acc_q    <= PRIME;
                    sd_q     <= 1'b0;
                    active_q <= bus_if.en;
                    if (bus_if.en) state_q <= RUN;
                end
                RUN: begin
                    if (bus_if.en) begin
                        acc_q    <= acc_d;
                        sd_q     <= carry_d;
                        active_q <= 1'b1;
                    end else begin
                        // Leaving RUN re-primes so a restart repeats the same sequence.
                        state_q  <= IDLE;
                        acc_q    <= PRIME;
                        sd_q     <= 1'b0;
                        active_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.sd_out = sd_q;
    assign bus_if.active = active_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_dds_sd_dac.sv
// Self-checking bench for dds_sd_dac (default build, signed input, W=12).
module tb_dds_sd_dac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    dds_sd_dac_if #(.W(12)) bus ();

    dds_sd_dac #(.W(12), .SIGNED_IN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_if      (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: total accumulated sum since priming; output bit is the
    // increase of its integer part in units of 2^W.
    longint s_acc = 2048;
    int     m_h   = 2048;
    bit     m_run = 1'b0;
    logic   exp_sd = 1'b0;
    logic   exp_active = 1'b0;
    logic   exp_q[$];

    task automatic model_reset();
        s_acc = 2048; m_h = 2048; m_run = 1'b0; exp_sd = 1'b0; exp_active = 1'b0;
    endtask

    task automatic tick(input logic en, input logic [11:0] smp, input logic vld);
        longint old;
        @(negedge clk);
        bus.en = en; bus.sample = smp; bus.sample_vld = vld;
        @(posedge clk);
        if (m_run && en) begin
            old   = s_acc;
            s_acc = s_acc + m_h;
            exp_sd = ((s_acc / 4096) - (old / 4096)) != 0;
        end else begin
            s_acc  = 2048;
            exp_sd = 1'b0;
        end
        exp_active = en;
        m_run = en;
        if (vld) m_h = (int'(smp) + 2048) % 4096;
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.sample = '0; bus.sample_vld = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.sd_out !== 1'b0 || bus.active !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial sd_out=%b active=%b state=%b required 0 0 0", bus.sd_out, bus.active, dbg_state);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, 12'h000, 1'b0);
        checks++;
        if (bus.sd_out !== 1'b1 || bus.active !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun sd_out=%b active=%b required 1 1", bus.sd_out, bus.active);
        end
        @(negedge clk); rst_n = 1'b0; #1;
        checks++;
        if (bus.sd_out !== 1'b0 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL reset_async sd_out=%b active=%b required 0 0", bus.sd_out, bus.active);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); bus.en = 1'b0; rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dbg_state !== 1'b0 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL reset_release state=%b active=%b required 0 0", dbg_state, bus.active);
        end
    endtask

    task automatic test_midscale();
        logic want;
        tick(1'b1, 12'h000, 1'b0);
        checks++;
        if (bus.active !== 1'b1 || bus.sd_out !== 1'b0) begin
            errors++;
            $display("FAIL midscale_first active=%b sd_out=%b required 1 0", bus.active, bus.sd_out);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 12'h000, 1'b0);
            want = (i % 2 == 0);
            checks++;
            if (bus.sd_out !== want || bus.sd_out !== exp_sd) begin
                errors++;
                $display("FAIL midscale_bit i=%0d sd_out=%b required %b", i, bus.sd_out, want);
            end
        end
    endtask

    task automatic test_density();
        int ones = 0;
        tick(1'b1, 12'h400, 1'b1);
        for (int i = 0; i < 100; i++) tick(1'b1, 12'h000, 1'b0);
        for (int i = 0; i < 4096; i++) begin
            tick(1'b1, 12'h000, 1'b0);
            ones += bus.sd_out;
            checks++;
            if (bus.sd_out !== exp_sd || bus.active !== exp_active) begin
                errors++;
                $display("FAIL density_cyc i=%0d sd_out=%b/%b active=%b/%b", i, bus.sd_out, exp_sd, bus.active, exp_active);
            end
        end
        checks++;
        if (ones != 3072) begin
            errors++;
            $display("FAIL density_ones got=%0d required=3072", ones);
        end
    endtask

    task automatic test_extremes();
        int ones = 0;
        int zeros = 0;
        tick(1'b1, 12'h800, 1'b1);
        tick(1'b1, 12'h000, 1'b0);
        for (int i = 0; i < 8192; i++) begin
            tick(1'b1, 12'h000, 1'b0);
            ones += bus.sd_out;
        end
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL extreme_zero ones=%0d required=0", ones);
        end
        tick(1'b1, 12'h7FF, 1'b1);
        tick(1'b1, 12'h000, 1'b0);
        for (int i = 0; i < 8192; i++) begin
            tick(1'b1, 12'h000, 1'b0);
            zeros += (bus.sd_out == 1'b0);
            checks++;
            if (bus.sd_out !== exp_sd) begin
                errors++;
                $display("FAIL extreme_full_cyc i=%0d sd_out=%b required %b", i, bus.sd_out, exp_sd);
            end
        end
        checks++;
        if (zeros != 2) begin
            errors++;
            $display("FAIL extreme_full zeros=%0d required=2", zeros);
        end
    endtask

    task automatic test_stop_restart();
        logic want;
        tick(1'b0, 12'h123, 1'b1);
        tick(1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 12'h000, 1'b0);
            exp_q.push_back(exp_sd);
            checks++;
            if (bus.sd_out !== exp_sd || bus.active !== exp_active) begin
                errors++;
                $display("FAIL run1_cyc i=%0d sd_out=%b/%b active=%b/%b", i, bus.sd_out, exp_sd, bus.active, exp_active);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 12'h000, 1'b0);
            checks++;
            if (bus.sd_out !== 1'b0 || bus.active !== 1'b0 || dbg_state !== 1'b0) begin
                errors++;
                $display("FAIL stop i=%0d sd_out=%b active=%b state=%b required 0 0 0", i, bus.sd_out, bus.active, dbg_state);
            end
        end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 12'h000, 1'b0);
            want = exp_q.pop_front();
            checks++;
            if (bus.sd_out !== want) begin
                errors++;
                $display("FAIL restart_bit i=%0d sd_out=%b required %b", i, bus.sd_out, want);
            end
        end
    endtask

    task automatic test_random();
        logic e, v;
        logic [11:0] s;
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(0, 31) != 0);
            v = ($urandom_range(0, 7) == 0);
            s = 12'($urandom_range(0, 4095));
            tick(e, s, v);
            checks++;
            if (bus.sd_out !== exp_sd || bus.active !== exp_active) begin
                errors++;
                $display("FAIL random_cyc i=%0d sd_out=%b/%b active=%b/%b", i, bus.sd_out, exp_sd, bus.active, exp_active);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] s;
        for (int i = 0; i < 500; i++) begin
            s = 12'($urandom_range(0, 4095));
            tick(1'b1, s, 1'b1);
            checks++;
            if (bus.sd_out !== exp_sd || bus.active !== exp_active) begin
                errors++;
                $display("FAIL b2b_cyc i=%0d sd_out=%b/%b active=%b/%b", i, bus.sd_out, exp_sd, bus.active, exp_active);
            end
        end
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_density();
        test_extremes();
        test_stop_restart();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
